// File: rtl/bk_sector_seq.sv
// bk_sector_seq: turns OSD load/save requests into a run of SD sector requests, one slot at a time.
// Optional ack-wait watchdog in REQ is enabled by defining BK_TIMEOUT_EN.
module bk_sector_seq #(
  parameter int SECT_BITS = 6,
  parameter int SLOT_BITS = 2,
  parameter int TMO_BITS  = 24
) (
  input  logic                 clk_sys,
  input  logic                 RESET_n,
  input  logic                 ena,
  input  logic [SLOT_BITS-1:0] slot,
  input  logic                 load_req,
  input  logic                 save_req,
  output logic [31:0]          sd_lba,
  output logic                 sd_rd,
  output logic                 sd_wr,
  input  logic                 sd_ack,
  output logic                 busy,
  output logic                 loading,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER} state_t;

  if (TMO_BITS < 2 || SECT_BITS + SLOT_BITS > 32) begin : g_param_check
    $error("bk_sector_seq: unsupported parameter combination");
  end

  state_t      r_state;
  logic        r_old_load;
  logic        r_old_save;
  logic        r_old_ack;
  logic        r_armed;
  logic        w_load_start;
  logic        w_save_start;
  logic        w_ack_rise;
  logic        w_ack_fall;
  logic        w_last_sect;
  logic [31:0] w_base_lba;

  // r_armed keeps a request that is already high at reset release from counting as an edge.
  assign w_load_start = r_armed & ~r_old_load & load_req & ena;
  assign w_save_start = r_armed & ~r_old_save & save_req & ena;
  assign w_ack_rise   = ~r_old_ack & sd_ack;
  assign w_ack_fall   = r_old_ack & ~sd_ack;
  assign w_last_sect  = &sd_lba[SECT_BITS-1:0];
  assign w_base_lba   = 32'({slot, {SECT_BITS{1'b0}}});

`ifdef BK_TIMEOUT_EN
  logic [TMO_BITS-1:0] r_tmo;
  logic [TMO_BITS-1:0] w_tmo_next;
  logic                w_tmo_expire;

  assign w_tmo_next   = r_tmo + 1'b1;
  assign w_tmo_expire = &w_tmo_next;

  // Leaving REQ always clears the count, so every entry to REQ starts from zero.
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      r_tmo <= '0;
    end else if (r_state != ST_REQ) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= w_tmo_next;
    end
  end
`else
  assign err = 1'b0;
`endif

  // NOTE: all state here is sequential, so every assignment is non-blocking.
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state    <= ST_IDLE;
      r_old_load <= 1'b0;
      r_old_save <= 1'b0;
      r_old_ack  <= 1'b0;
      r_armed    <= 1'b0;
      sd_lba     <= '0;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      busy       <= 1'b0;
      loading    <= 1'b0;
      done       <= 1'b0;
`ifdef BK_TIMEOUT_EN
      err        <= 1'b0;
`endif
    end else begin
      r_armed    <= 1'b1;
      r_old_load <= load_req & ena;
      r_old_save <= save_req & ena;
      r_old_ack  <= sd_ack;
      // NOTE: pulse outputs default low each cycle; only the completing branch raises them.
      done       <= 1'b0;
`ifdef BK_TIMEOUT_EN
      err        <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          // Load has priority; a simultaneous save edge is simply dropped.
          if (w_load_start || w_save_start) begin
            r_state <= ST_REQ;
            busy    <= 1'b1;
            loading <= w_load_start;
            sd_lba  <= w_base_lba;
            sd_rd   <= w_load_start;
            sd_wr   <= ~w_load_start;
          end
        end
        ST_REQ: begin
          if (w_ack_rise) begin
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
            r_state <= ST_XFER;
          end
`ifdef BK_TIMEOUT_EN
          else if (w_tmo_expire) begin
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
            busy    <= 1'b0;
            loading <= 1'b0;
            err     <= 1'b1;
            r_state <= ST_IDLE;
          end
`endif
        end
        ST_XFER: begin
          if (w_ack_fall) begin
            if (w_last_sect) begin
              busy    <= 1'b0;
              loading <= 1'b0;
              done    <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              // loading doubles as the latched operation type for the whole sequence.
              sd_lba  <= sd_lba + 32'd1;
              sd_rd   <= loading;
              sd_wr   <= ~loading;
              r_state <= ST_REQ;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bk_sector_seq.sv
// Testbench for bk_sector_seq: randomized ack timing checked against a sector-list reference model.
// Define BK_TIMEOUT_EN to also exercise the REQ watchdog with a 4-bit counter.
`timescale 1ns/1ps
module tb_bk_sector_seq;

  localparam int SECT_BITS = 6;
  localparam int SLOT_BITS = 2;
`ifdef BK_TIMEOUT_EN
  localparam int TMO_BITS = 4;
`else
  localparam int TMO_BITS = 24;
`endif
  localparam int NSECT = 1 << SECT_BITS;

  logic                 clk_sys  = 1'b0;
  logic                 RESET_n  = 1'b0;
  logic                 ena      = 1'b0;
  logic [SLOT_BITS-1:0] slot     = '0;
  logic                 load_req = 1'b0;
  logic                 save_req = 1'b0;
  logic                 sd_ack   = 1'b0;
  logic [31:0]          sd_lba;
  logic                 sd_rd;
  logic                 sd_wr;
  logic                 busy;
  logic                 loading;
  logic                 done;
  logic                 err;

  int n_cmp       = 0;
  int n_bad       = 0;
  int done_cnt    = 0;
  int err_cnt     = 0;
  int overlap_cnt = 0;
  int exp_done    = 0;

  always #5 clk_sys = ~clk_sys;

  bk_sector_seq #(
    .SECT_BITS(SECT_BITS),
    .SLOT_BITS(SLOT_BITS),
    .TMO_BITS (TMO_BITS)
  ) dut (
    .clk_sys (clk_sys),
    .RESET_n (RESET_n),
    .ena     (ena),
    .slot    (slot),
    .load_req(load_req),
    .save_req(save_req),
    .sd_lba  (sd_lba),
    .sd_rd   (sd_rd),
    .sd_wr   (sd_wr),
    .sd_ack  (sd_ack),
    .busy    (busy),
    .loading (loading),
    .done    (done),
    .err     (err)
  );

  always @(negedge clk_sys) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (sd_rd && sd_wr) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_lba"}, sd_lba, 32'd0);
    check({tag, "_rd"}, 32'(sd_rd), 32'd0);
    check({tag, "_wr"}, 32'(sd_wr), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_loading"}, 32'(loading), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // Reference model: a sequence is the sector list base..base+63 of one request type,
  // each request present from the start edge or the previous ack fall, dropped on ack rise.
  // Caller has just driven the start edge at a negedge.
  task automatic run_seq(input bit is_load, input int slot_v, input bit fiddle,
                         input bit hold_reqs, input bit poke_save, input int abort_at);
    logic [31:0] base;
    int          lat;
    int          hi;
    base = 32'(slot_v) * 32'(NSECT);
    for (int k = 0; k < NSECT; k++) begin
      @(negedge clk_sys);
      check("req_rd", 32'(sd_rd), 32'(is_load));
      check("req_wr", 32'(sd_wr), 32'(!is_load));
      check("req_lba", sd_lba, base + 32'(k));
      check("req_busy", 32'(busy), 32'd1);
      check("req_loading", 32'(loading), 32'(is_load));
      if (k == 0 && !hold_reqs) begin
        load_req = 1'b0;
        save_req = 1'b0;
      end
      if (poke_save && k == 5) save_req = 1'b0;
      if (poke_save && k == 6) save_req = 1'b1;
      if (fiddle) begin
        slot = SLOT_BITS'($urandom);
        ena  = !(k >= 10 && k < 20);
      end
      lat = $urandom_range(0, 2);
      for (int l = 0; l < lat; l++) begin
        @(negedge clk_sys);
        check("req_hold", 32'(sd_rd | sd_wr), 32'd1);
      end
      sd_ack = 1'b1;
      hi = (k == abort_at) ? 4 : $urandom_range(1, 10);
      for (int h = 0; h < hi; h++) begin
        @(negedge clk_sys);
        check("xfer_req_low", 32'(sd_rd | sd_wr), 32'd0);
        check("xfer_busy", 32'(busy), 32'd1);
        check("xfer_loading", 32'(loading), 32'(is_load));
        if (k == abort_at && h == 1) begin
          RESET_n = 1'b0;
          #1;
          check_all_zero("async_rst");
          return;
        end
      end
      sd_ack = 1'b0;
    end
    @(negedge clk_sys);
    check("end_done", 32'(done), 32'd1);
    check("end_busy", 32'(busy), 32'd0);
    check("end_loading", 32'(loading), 32'd0);
    check("end_req", 32'(sd_rd | sd_wr), 32'd0);
    exp_done++;
    @(negedge clk_sys);
    check("end_done_pulse", 32'(done), 32'd0);
    ena = 1'b1;
  endtask

  task automatic idle_window(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      if (busy || sd_rd || sd_wr) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    int op;
    int sv;
    int wr_cyc;
    int rd_cyc;
    int err_seen;
    int done_snap;

    // Reset state
    repeat (3) @(negedge clk_sys);
    check_all_zero("reset");
    RESET_n = 1'b1;
    ena     = 1'b1;
    repeat (3) @(negedge clk_sys);

    // Save slot 2, with slot and ena disturbed mid-sequence
    slot     = 2'd2;
    save_req = 1'b1;
    run_seq(1'b0, 2, 1'b1, 1'b0, 1'b0, -1);

    // Load slot 0
    slot     = 2'd0;
    load_req = 1'b1;
    run_seq(1'b1, 0, 1'b0, 1'b0, 1'b0, -1);

    // Random operations and slots
    for (int r = 0; r < 3; r++) begin
      op = $urandom_range(0, 1);
      sv = $urandom_range(0, 3);
      repeat ($urandom_range(1, 4)) @(negedge clk_sys);
      slot = SLOT_BITS'(sv);
      if (op == 1) load_req = 1'b1;
      else save_req = 1'b1;
      run_seq(op == 1, sv, 1'(($urandom & 1)), 1'b0, 1'b0, -1);
    end

    // Edge with ena low is ignored; raising ena while load_req is high starts a load
    ena      = 1'b0;
    slot     = 2'd1;
    load_req = 1'b1;
    idle_window("ena_low_no_start", 10);
    ena = 1'b1;
    run_seq(1'b1, 1, 1'b0, 1'b0, 1'b0, -1);

    // Simultaneous edges: load only; a save edge during the load is lost
    repeat (3) @(negedge clk_sys);
    slot     = 2'd3;
    load_req = 1'b1;
    save_req = 1'b1;
    run_seq(1'b1, 3, 1'b0, 1'b1, 1'b1, -1);
    idle_window("no_second_seq", 20);
    load_req = 1'b0;
    save_req = 1'b0;
    repeat (2) @(negedge clk_sys);

    // Asynchronous reset during sector 10, request held through release
    slot     = 2'd1;
    load_req = 1'b1;
    run_seq(1'b1, 1, 1'b0, 1'b1, 1'b0, 10);
    sd_ack = 1'b0;
    @(negedge clk_sys);
    check_all_zero("in_reset");
    RESET_n = 1'b1;
    idle_window("no_start_after_rst", 20);
    load_req = 1'b0;
    @(negedge clk_sys);
    slot     = 2'd2;
    load_req = 1'b1;
    run_seq(1'b1, 2, 1'b0, 1'b0, 1'b0, -1);

`ifdef BK_TIMEOUT_EN
    // Watchdog: no ack ever arrives
    repeat (3) @(negedge clk_sys);
    done_snap = done_cnt;
    wr_cyc    = 0;
    rd_cyc    = 0;
    err_seen  = 0;
    slot      = 2'd0;
    save_req  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_sys);
      if (i == 0) save_req = 1'b0;
      if (sd_wr) wr_cyc++;
      if (sd_rd) rd_cyc++;
      if (err) err_seen++;
    end
    check("tmo_wr_cycles", 32'(wr_cyc), 32'd15);
    check("tmo_rd_cycles", 32'(rd_cyc), 32'd0);
    check("tmo_err_pulses", 32'(err_seen), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_no_done", 32'(done_cnt - done_snap), 32'd0);
    check("err_total", 32'(err_cnt), 32'd1);
`else
    check("err_total", 32'(err_cnt), 32'd0);
`endif

    repeat (3) @(negedge clk_sys);
    check("done_total", 32'(done_cnt), 32'(exp_done));
    check("rd_wr_exclusive", 32'(overlap_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
